gate_checker: RTL and testbench

Sequential self-test engine for the team's 2-input and 1-input behavioural logic gates (AND, OR, NOT). On a start pulse it drives the gate-under-test inputs through every input combination, waits a programmable settle time, samples the gate output, compares it against the expected truth table, and reports a per-vector fail mask, error count and pass flag. It sits in the testbench/bring-up layer, on the driving side of the gate x/y/out interface.

---
 rtl/gate_checker.sv | 140 ++++++++++++++
 tb/tb_gate_checker.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_checker.sv
// rtl/gate_checker.sv - sequential truth-table self-test engine for AND/OR/NOT gate slots
// Define GATE_CHECKER_XOR_EN to make sel=11 a legal XOR check instead of a bad_sel run.
module gate_checker #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] sel,
    input  logic       dut_out,
    output logic       x,
    output logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       bad_sel,
    output logic [3:0] fail_vec,
    output logic [2:0] err_count
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [1:0] SEL_AND = 2'b00;
    localparam logic [1:0] SEL_OR  = 2'b01;
    localparam logic [1:0] SEL_NOT = 2'b10;
    localparam logic [1:0] SEL_XOR = 2'b11;
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state;
    state_t     state_nx;
    logic [1:0] sel_q;
    logic [1:0] idx;
    logic [3:0] wait_cnt;
    logic       sel_ok;
    logic       last_vec;
    logic       expected;
    logic       mismatch;

    always_comb begin
`ifdef GATE_CHECKER_XOR_EN
        sel_ok = 1'b1;
`else
        sel_ok = (sel != SEL_XOR);
`endif
    end

    // NOT only walks x through 0/1, so it finishes after two vectors
    assign last_vec = (sel_q == SEL_NOT) ? (idx == 2'd1) : (idx == 2'd3);

    always_comb begin
        expected = 1'b0;
        case (sel_q)
            SEL_AND: expected = x & y;
            SEL_OR:  expected = x | y;
            SEL_NOT: expected = ~x;
            SEL_XOR: expected = x ^ y;
            default: expected = 1'b0;
        endcase
    end

    // Case equality so an X or Z on the gate output is flagged, not silently accepted
    assign mismatch = !(dut_out === expected);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = sel_ok ? S_DRIVE : S_DONE;
            S_DRIVE: state_nx = S_WAIT;
            S_WAIT:  if (wait_cnt == SETTLE_LAST) state_nx = S_CHECK;
            S_CHECK: state_nx = last_vec ? S_DONE : S_DRIVE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q     <= 2'b00;
            idx       <= 2'd0;
            wait_cnt  <= 4'd0;
            x         <= 1'b0;
            y         <= 1'b0;
            pass      <= 1'b0;
            bad_sel   <= 1'b0;
            fail_vec  <= 4'd0;
            err_count <= 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sel_q     <= sel;
                        idx       <= 2'd0;
                        fail_vec  <= 4'd0;
                        err_count <= 3'd0;
                        pass      <= 1'b0;
                        bad_sel   <= !sel_ok;
                    end
                end
                S_DRIVE: begin
                    x        <= (sel_q == SEL_NOT) ? idx[0] : idx[1];
                    y        <= (sel_q == SEL_NOT) ? 1'b0 : idx[0];
                    wait_cnt <= 4'd0;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 4'd1;
                end
                S_CHECK: begin
                    if (mismatch) begin
                        fail_vec[idx] <= 1'b1;
                        err_count     <= err_count + 3'd1;
                    end
                    // pass is settled here so it is already valid while done is high
                    if (last_vec) begin
                        pass <= (fail_vec == 4'd0) && !mismatch;
                    end else begin
                        idx <= idx + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == S_DRIVE) || (state == S_WAIT) || (state == S_CHECK);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_gate_checker.sv
// tb/tb_gate_checker.sv - randomized scoreboard bench for gate_checker
module tb_gate_checker;
    localparam int S  = 1;
    localparam int VT = 2 + S;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] sel   = 2'b00;
    logic       dut_out;
    logic       x, y, busy, done, pass, bad_sel;
    logic [3:0] fail_vec;
    logic [2:0] err_count;

    logic [1:0] gate_sel = 2'b00;
    logic [3:0] flip     = 4'b0000;
    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         e;
        int         dk;
        bit         legal;
        logic [3:0] fv;
        logic [2:0] err;
        bit         pass;
        bit         bad;
        logic [7:0] xys;
    } exp_t;

    exp_t exp_q[$];

    gate_checker #(.SETTLE(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sel       (sel),
        .dut_out   (dut_out),
        .x         (x),
        .y         (y),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .bad_sel   (bad_sel),
        .fail_vec  (fail_vec),
        .err_count (err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Gate in the slot: the ideal truth table with per-input-combination faults flipped in
    function automatic logic truth(input logic [1:0] g, input logic a, input logic b);
        case (g)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return ~a;
            default: return a ^ b;
        endcase
    endfunction

    assign dut_out = truth(gate_sel, x, y) ^ flip[{x, y}];

    function automatic void chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic exp_t model(input logic [1:0] s, input logic [3:0] fl, input int e);
        exp_t r;
        int n;
        logic [1:0] v;
`ifdef GATE_CHECKER_XOR_EN
        r.legal = 1'b1;
`else
        r.legal = (s != 2'b11);
`endif
        n     = (s == 2'b10) ? 2 : 4;
        r.e   = e;
        r.fv  = 4'd0;
        r.xys = 8'd0;
        for (int i = 0; i < n; i++) begin
            v = (n == 2) ? {i[0], 1'b0} : i[1:0];
            r.xys[2*i +: 2] = v;
            if (r.legal) r.fv[i] = fl[v];
        end
        r.err  = 3'($countones(r.fv));
        r.pass = r.legal && (r.fv == 4'd0);
        r.bad  = !r.legal;
        r.dk   = r.legal ? n * VT + 1 : 1;
        return r;
    endfunction

    exp_t mh;
    int   mk, mph, mvi;

    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_q.size() > 0) begin
                mh = exp_q[0];
                mk = cyc - mh.e + 1;
                if (done) begin
                    chk("done_cycle", mk, mh.dk);
                    chk("fail_vec", int'(fail_vec), int'(mh.fv));
                    chk("err_count", int'(err_count), int'(mh.err));
                    chk("pass", int'(pass), int'(mh.pass));
                    chk("bad_sel", int'(bad_sel), int'(mh.bad));
                    chk("busy_in_done", int'(busy), 0);
                    void'(exp_q.pop_front());
                end else if (mk > mh.dk + 4) begin
                    chk("done_timeout", mk, mh.dk);
                    void'(exp_q.pop_front());
                end else if (mh.legal && mk >= 1 && mk < mh.dk) begin
                    chk("busy_in_run", int'(busy), 1);
                    mph = (mk - 1) % VT;
                    mvi = (mk - 1) / VT;
                    if (mph >= 1) chk("xy_vector", int'({x, y}), int'(mh.xys[2*mvi +: 2]));
                end
            end else if (done) begin
                chk("unexpected_done", 1, 0);
            end
        end
    end

    task automatic launch(input logic [1:0] s, input logic [3:0] fl, output int e, output int dk);
        exp_t r;
        e  = cyc + 1;
        r  = model(s, fl, e);
        dk = r.dk;
        exp_q.push_back(r);
        gate_sel = s;
        flip     = fl;
        sel      = s;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: quiet, 1: random start/sel noise while busy, 2: one extra start in cycle 4
    task automatic finish_run(input int e, input int dk, input int mode);
        int guard;
        int k;
        guard = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            k = cyc - e + 1;
            if (mode == 1 && k >= 2 && k <= dk - 1) begin
                start = 1'($urandom);
                sel   = 2'($urandom);
            end else if (mode == 2 && k == 4) begin
                start = 1'b1;
                sel   = 2'b10;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        start = 1'b0;
        if (exp_q.size() != 0) begin
            chk("run_drain", exp_q.size(), 0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_x"}, int'(x), 0);
        chk({tag, "_y"}, int'(y), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_pass"}, int'(pass), 0);
        chk({tag, "_bad_sel"}, int'(bad_sel), 0);
        chk({tag, "_fail_vec"}, int'(fail_vec), 0);
        chk({tag, "_err_count"}, int'(err_count), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e, e2, dk;
        exp_t r;
        logic [1:0] s;
        logic [3:0] fl;

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        launch(2'b00, 4'b0000, e, dk);
        finish_run(e, dk, 0);
        launch(2'b01, 4'b1110, e, dk);
        finish_run(e, dk, 0);
        launch(2'b10, 4'b1111, e, dk);
        finish_run(e, dk, 0);
        launch(2'b11, 4'b0000, e, dk);
        finish_run(e, dk, 0);

        // start held high across two runs: one IDLE cycle between them
        e  = cyc + 1;
        r  = model(2'b00, 4'b0000, e);
        dk = r.dk;
        exp_q.push_back(r);
        e2 = e + dk + 1;
        exp_q.push_back(model(2'b00, 4'b0000, e2));
        gate_sel = 2'b00;
        flip     = 4'b0000;
        sel      = 2'b00;
        start    = 1'b1;
        while (cyc < e2) @(negedge clk);
        start = 1'b0;
        finish_run(e2, dk, 0);

        for (int i = 0; i < 30; i++) begin
            s  = 2'($urandom);
            fl = 4'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            launch(s, fl, e, dk);
            finish_run(e, dk, int'($urandom_range(0, 1)));
        end

        // reset in cycle 6 of an AND run, then a run with an ignored second start
        launch(2'b00, 4'b0000, e, dk);
        while (cyc - e + 1 < 6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("midrun_reset");
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        launch(2'b00, 4'b0000, e, dk);
        finish_run(e, dk, 2);

        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
